// File: rtl/sat_pkg.sv
// Shared types and constants for the SAT variable integrator.
package sat_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned SumWDefault = 6;
  localparam int unsigned MaxVotes    = 32;

endpackage

// File: rtl/sat_acc_update.sv
// Combinational accumulator step: adds UP-DOWN to one accumulator with saturation and
// derives the resulting variable value and whether it flipped.
module sat_acc_update
  import sat_pkg::*;
#(
  parameter int unsigned SUM_W = SumWDefault,
  parameter int unsigned ACC_W = 8
) (
  input  logic [ACC_W-1:0] acc_in,
  input  logic [SUM_W-1:0] sum_up,
  input  logic [SUM_W-1:0] sum_down,
  input  logic             cur_value,
  output logic [ACC_W-1:0] acc_new,
  output logic             new_value,
  output logic             flip
);

  logic signed [SUM_W:0] delta;
  logic        [ACC_W:0] acc_ext;
  logic        [ACC_W:0] delta_ext;
  logic        [ACC_W:0] sum;
  logic                  positive;
  logic                  negative;

  assign delta     = $signed({1'b0, sum_up}) - $signed({1'b0, sum_down});
  assign acc_ext   = {acc_in[ACC_W-1], acc_in};
  assign delta_ext = {{(ACC_W - SUM_W){delta[SUM_W]}}, delta};
  assign sum       = acc_ext + delta_ext;

  // Top two bits disagree only when the sum left the ACC_W-bit signed range.
  always_comb begin
    acc_new = sum[ACC_W-1:0];
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      acc_new = sum[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
    end
  end

  assign negative  = acc_new[ACC_W-1];
  assign positive  = ~acc_new[ACC_W-1] & (|acc_new[ACC_W-2:0]);
  assign new_value = positive ? 1'b1 : (negative ? 1'b0 : cur_value);
  assign flip      = new_value ^ cur_value;

endmodule

// File: rtl/sat_var_integrator.sv
// Round-robin per-variable vote integrator: saturating accumulators, sign-derived assignment,
// and convergence / sweep-limit detection.
module sat_var_integrator
  import sat_pkg::*;
#(
  parameter int unsigned NUM_VARS   = 32,
  parameter int unsigned SUM_W      = SumWDefault,
  parameter int unsigned ACC_W      = 8,
  parameter int unsigned MAX_SWEEPS = 255,
  localparam int unsigned IdxW      = $clog2(NUM_VARS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sum_valid,
  input  logic [SUM_W-1:0]    sum_up,
  input  logic [SUM_W-1:0]    sum_down,
  output logic                sum_ready,
  output logic [IdxW-1:0]     var_idx,
  output logic [NUM_VARS-1:0] var_value,
  output logic [7:0]          sweep_cnt,
  output logic                done,
  output logic                converged
);

  state_e                   state_q;
  logic signed [ACC_W-1:0]  acc_q [NUM_VARS];
  logic                     flip_q;

  logic [ACC_W-1:0] acc_new;
  logic             new_value;
  logic             flip;
  logic             last_var;
  logic [7:0]       sweep_next;

  sat_acc_update #(
    .SUM_W(SUM_W),
    .ACC_W(ACC_W)
  ) u_acc_update (
    .acc_in   (acc_q[var_idx]),
    .sum_up   (sum_up),
    .sum_down (sum_down),
    .cur_value(var_value[var_idx]),
    .acc_new  (acc_new),
    .new_value(new_value),
    .flip     (flip)
  );

  assign last_var   = (var_idx == IdxW'(NUM_VARS - 1));
  assign sweep_next = sweep_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      for (int i = 0; i < NUM_VARS; i++) acc_q[i] <= '0;
      var_value <= '0;
      var_idx   <= '0;
      sweep_cnt <= '0;
      flip_q    <= 1'b0;
      sum_ready <= 1'b0;
      done      <= 1'b0;
      converged <= 1'b0;
    end else if (start) begin
      // Same clear as reset; any simultaneous transfer is dropped.
      state_q   <= StRun;
      for (int i = 0; i < NUM_VARS; i++) acc_q[i] <= '0;
      var_value <= '0;
      var_idx   <= '0;
      sweep_cnt <= '0;
      flip_q    <= 1'b0;
      sum_ready <= 1'b1;
      done      <= 1'b0;
      converged <= 1'b0;
    end else if (state_q == StRun && sum_valid) begin
      acc_q[var_idx]     <= acc_new;
      var_value[var_idx] <= new_value;
      if (last_var) begin
        var_idx   <= '0;
        sweep_cnt <= sweep_next;
        // Convergence takes priority over the sweep limit.
        if (!(flip_q || flip)) begin
          state_q   <= StDone;
          sum_ready <= 1'b0;
          done      <= 1'b1;
          converged <= 1'b1;
        end else if (sweep_next == 8'(MAX_SWEEPS)) begin
          state_q   <= StDone;
          sum_ready <= 1'b0;
          done      <= 1'b1;
          converged <= 1'b0;
        end else begin
          flip_q <= 1'b0;
        end
      end else begin
        var_idx <= var_idx + IdxW'(1);
        flip_q  <= flip_q | flip;
      end
    end
  end

endmodule

// File: tb/tb_sat_var_integrator.sv
// Randomized bench for sat_var_integrator against a transaction-level model of the integrator.
module tb_sat_var_integrator;

  localparam int NV   = 32;
  localparam int MAXS = 255;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          sum_valid = 1'b0;
  logic [5:0]    sum_up = '0;
  logic [5:0]    sum_down = '0;
  logic          sum_ready;
  logic [4:0]    var_idx;
  logic [NV-1:0] var_value;
  logic [7:0]    sweep_cnt;
  logic          done;
  logic          converged;

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  // Model: state 0 = idle, 1 = running, 2 = finished.
  int            m_acc [NV];
  logic [NV-1:0] m_val;
  int            m_idx, m_sweep, m_state;
  bit            m_flip, m_conv;

  sat_var_integrator dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sum_valid(sum_valid),
    .sum_up   (sum_up),
    .sum_down (sum_down),
    .sum_ready(sum_ready),
    .var_idx  (var_idx),
    .var_value(var_value),
    .sweep_cnt(sweep_cnt),
    .done     (done),
    .converged(converged)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_i(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void m_clear(input int st);
    for (int i = 0; i < NV; i++) m_acc[i] = 0;
    m_val   = '0;
    m_idx   = 0;
    m_sweep = 0;
    m_state = st;
    m_flip  = 1'b0;
    m_conv  = 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int   a;
    logic nv;
    if (!rst_n) begin
      m_clear(0);
    end else if (start) begin
      m_clear(1);
    end else if (m_state == 1 && sum_valid) begin
      a = m_acc[m_idx] + int'(sum_up) - int'(sum_down);
      if (a > 127) a = 127;
      if (a < -128) a = -128;
      m_acc[m_idx] = a;
      nv = (a > 0) ? 1'b1 : ((a < 0) ? 1'b0 : m_val[m_idx]);
      if (nv != m_val[m_idx]) m_flip = 1'b1;
      m_val[m_idx] = nv;
      if (m_idx == NV - 1) begin
        m_idx = 0;
        m_sweep++;
        if (!m_flip) begin
          m_state = 2;
          m_conv  = 1'b1;
        end else if (m_sweep == MAXS) begin
          m_state = 2;
          m_conv  = 1'b0;
        end else begin
          m_flip = 1'b0;
        end
      end else begin
        m_idx++;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("sum_ready", sum_ready, (m_state == 1));
      check("var_idx", var_idx, m_idx);
      check("var_value", var_value, m_val);
      check("sweep_cnt", sweep_cnt, m_sweep);
      check("done", done, (m_state == 2));
      check("converged", converged, (m_state == 2) && m_conv);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Optional idle cycle, then one transfer; leaves sum_valid low afterwards.
  task automatic transfer(input int up, input int dn);
    if ($urandom_range(0, 3) == 0) begin
      sum_valid = 1'b0;
      sum_up    = 6'($urandom_range(0, 32));
      step();
    end
    sum_up    = 6'(up);
    sum_down  = 6'(dn);
    sum_valid = 1'b1;
    step();
    sum_valid = 1'b0;
  endtask

  // Drives var0 so that its sign changes on every visit: 0 -> 5 -> -5 -> 5 ...
  task automatic alt_votes(output int up, output int dn);
    if (m_acc[0] == 0) begin up = 5; dn = 0; end
    else if (m_acc[0] > 0) begin up = 0; dn = 10; end
    else begin up = 10; dn = 0; end
  endtask

  int up, dn, nz, budget;
  int sat_exp [14] = '{32, 64, 96, 127, 127, 95, 63, 31, -1, -33, -65, -97, -128, -128};

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_clear(0);
    #2 rst_n = 1'b0;
    cmp_en = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
    check("reset sum_ready", sum_ready, 0);
    check("reset var_idx", var_idx, 0);
    check("reset done", done, 0);

    // Basic transfers.
    pulse_start();
    check("start sum_ready", sum_ready, 1);
    sum_up = 6'd5; sum_down = 6'd2; sum_valid = 1'b1;
    step();
    check_i("acc0 after +3", int'(dut.acc_q[0]), 3);
    check_i("model acc0", m_acc[0], 3);
    check("var_value[0]", var_value[0], 1);
    check("var_idx after 1", var_idx, 1);
    sum_up = 6'd0; sum_down = 6'd7;
    step();
    sum_valid = 1'b0;
    check_i("acc1 after -7", int'(dut.acc_q[1]), -7);
    check("var_value[1]", var_value[1], 0);
    check("var_idx after 2", var_idx, 2);

    // Async reset in the middle of a sweep.
    budget = 200;
    while (m_idx != 9 && budget > 0) begin
      transfer($urandom_range(0, 32), $urandom_range(0, 32));
      budget--;
    end
    check_i("reached idx 9", m_idx, 9);
    #2 rst_n = 1'b0;
    #1;
    check("async rst var_idx", var_idx, 0);
    check("async rst var_value", var_value, 0);
    check("async rst sum_ready", sum_ready, 0);
    check("async rst sweep_cnt", sweep_cnt, 0);
    step();
    rst_n = 1'b1;
    sum_up = 6'd20; sum_down = 6'd0; sum_valid = 1'b1;
    repeat (4) step();
    sum_valid = 1'b0;
    check("idle ignores valid idx", var_idx, 0);
    check_i("idle ignores valid acc0", int'(dut.acc_q[0]), 0);

    // Saturation at both ends on var3, var0 keeps flipping so the run continues.
    pulse_start();
    for (int s = 0; s < 14; s++) begin
      for (int t = 0; t < NV; t++) begin
        if (m_idx == 0) alt_votes(up, dn);
        else if (m_idx == 3) begin up = (s < 5) ? 32 : 0; dn = (s < 5) ? 0 : 32; end
        else begin up = $urandom_range(0, 32); dn = $urandom_range(0, 32); end
        transfer(up, dn);
        if (t == 3) check_i($sformatf("acc3 sweep %0d", s), int'(dut.acc_q[3]), sat_exp[s]);
      end
    end
    check_i("model acc3 floor", m_acc[3], -128);

    // Convergence: sweep 1 flips only var0, sweep 2 has no net votes anywhere.
    pulse_start();
    for (int s = 0; s < 2; s++) begin
      for (int t = 0; t < NV; t++) begin
        if (s == 0 && t == 0) begin up = 3; dn = 0; end
        else begin up = $urandom_range(0, 32); dn = up; end
        transfer(up, dn);
      end
    end
    check("conv done", done, 1);
    check("conv converged", converged, 1);
    check("conv sweep_cnt", sweep_cnt, 2);
    check("conv sum_ready", sum_ready, 0);
    sum_up = 6'd32; sum_down = 6'd0; sum_valid = 1'b1;
    repeat (5) step();
    sum_valid = 1'b0;
    check("done hold var_value", var_value, 1);
    check("done hold var_idx", var_idx, 0);
    check("done hold sweep_cnt", sweep_cnt, 2);

    // Sweep limit: var0 flips every sweep so the run never converges.
    pulse_start();
    budget = MAXS * NV + 10;
    while (m_state == 1 && budget > 0) begin
      if (m_idx == 0) alt_votes(up, dn);
      else begin up = $urandom_range(0, 32); dn = $urandom_range(0, 32); end
      transfer(up, dn);
      budget--;
    end
    check("timeout done", done, 1);
    check("timeout converged", converged, 0);
    check("timeout sweep_cnt", sweep_cnt, MAXS);
    check("timeout sum_ready", sum_ready, 0);
    check_i("model timeout sweeps", m_sweep, MAXS);
    transfer(1, 0);
    check("timeout no wrap", sweep_cnt, MAXS);

    // START coinciding with a transfer at idx 17 drops the transfer.
    pulse_start();
    for (int t = 0; t < 17; t++) transfer($urandom_range(1, 32), 0);
    check("reached idx 17", var_idx, 17);
    start = 1'b1; sum_valid = 1'b1; sum_up = 6'd30; sum_down = 6'd0;
    step();
    start = 1'b0; sum_valid = 1'b0;
    nz = 0;
    for (int i = 0; i < NV; i++) if (dut.acc_q[i] != 0) nz++;
    check_i("restart accs cleared", nz, 0);
    check("restart var_idx", var_idx, 0);
    check("restart var_value", var_value, 0);
    check("restart sum_ready", sum_ready, 1);

    // Free-running random traffic with occasional restarts.
    for (int c = 0; c < 3000; c++) begin
      start     = ($urandom_range(0, 99) == 0);
      sum_valid = ($urandom_range(0, 3) != 0);
      sum_up    = 6'($urandom_range(0, 32));
      sum_down  = ($urandom_range(0, 1) == 0) ? sum_up : 6'($urandom_range(0, 32));
      step();
    end
    start = 1'b0;
    sum_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
